mem_read_responder: RTL

Memory-side responder for the four-state go/ws/rd/ds read controller. It sits on the opposite end of the rd/ws/ds handshake from that controller. It watches rd, holds ws high for a programmable number of wait cycles, and then presents one word from a small internal RAM on rdata. It completes the transfer when the controller pulses ds. The block stands in for a slow memory in lab top-levels and benches.

---
 rtl/mem_read_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_read_responder.sv
// mem_read_responder
//   Memory-side responder for the go/ws/rd/ds read controller. It watches rd,
//   holds ws high for wait_len cycles, and then presents one word from a small
//   internal RAM on rdata with rvalid. A ds strobe from the controller
//   completes the transfer and advances the read address.
//
// Optional feature macro: RESP_ERR_EN
//   When defined, aborts (rd dropped before ds) and a ds strobe outside
//   R_READY set the sticky err output, which only reset clears.
//   When undefined, err is tied to 0.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-high
//   rd         : read request from the controller
//   ds         : done strobe from the controller
//   wait_len   : wait cycles to insert, sampled when a request is accepted
//   wr_en      : RAM preload write enable, honoured only in R_IDLE
//   wr_addr    : preload address
//   wr_data    : preload data
//   ws         : wait-state request, high only in R_WAIT
//   rdata      : read data, captured on entry to R_READY and held afterwards
//   rvalid     : high only in R_READY
//   rd_addr    : address served by the next/current read
//   txn_count  : completed transactions (wraps)
//   err        : sticky protocol error
//   state_dbg  : registered FSM state (0 idle, 1 wait, 2 ready)
//
// Handshake: a request is accepted on the first rising edge where rd=1 in
// R_IDLE. The controller must hold rd high until rvalid has been seen, then
// drop rd while pulsing ds for one cycle. Dropping rd at any other point is
// an abort.
module mem_read_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              ds,
  input  logic [3:0]        wait_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ws,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  txn_count,
  output logic              err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_READY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;
  logic              mem_we;
  logic              abort;
  logic              stray_ds;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rdata_d     = rdata_q;
    rd_addr_d   = rd_addr_q;
    txn_count_d = txn_count_q;
    mem_we      = 1'b0;
    abort       = 1'b0;
    stray_ds    = ds && (state_q != R_READY);

    case (state_q)
      R_IDLE: begin
        // The RAM write port is only open while idle; a simultaneous read
        // accept sees the pre-write contents.
        mem_we = wr_en;
        if (rd) begin
          if (wait_len == 4'd0) begin
            state_d = R_READY;
            rdata_d = mem_q[rd_addr_q];
          end else begin
            state_d = R_WAIT;
            wcnt_d  = wait_len;
          end
        end
      end
      R_WAIT: begin
        if (!rd) begin
          state_d = R_IDLE;
          abort   = 1'b1;
        end else if (wcnt_q == 4'd1) begin
          state_d = R_READY;
          rdata_d = mem_q[rd_addr_q];
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      R_READY: begin
        // rd still high is the controller's DLY-to-DONE gap: just hold.
        if (!rd) begin
          state_d = R_IDLE;
          if (ds) begin
            rd_addr_d   = rd_addr_q + ADDR_W'(1);
            txn_count_d = txn_count_q + CNT_W'(1);
          end else begin
            abort = 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= R_IDLE;
      wcnt_q      <= 4'd0;
      rdata_q     <= '0;
      rd_addr_q   <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rdata_q     <= rdata_d;
      rd_addr_q   <= rd_addr_d;
      txn_count_q <= txn_count_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef RESP_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | abort | stray_ds;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_detect;
  assign unused_err_detect = abort ^ stray_ds;
  assign err = 1'b0;
`endif

  // Moore outputs decoded from the registered state, so reset drops them
  // immediately.
  assign ws        = (state_q == R_WAIT);
  assign rvalid    = (state_q == R_READY);
  assign rdata     = rdata_q;
  assign rd_addr   = rd_addr_q;
  assign txn_count = txn_count_q;
  assign state_dbg = state_q;

endmodule
